dds_voice_osc: RTL

//  Downstream of the note-to-DDS lookup: consumes the 32-bit phase increment (ADDER) for the current note.

---
 rtl/dds_voice_osc.sv | 106 ++++++++++
 1 files changed

// File: rtl/dds_voice_osc.sv
// Single-voice DDS oscillator: 32-bit phase accumulator with glide toward the
// target increment, hard sync on gate-on, and decimated saw/square/triangle output.
module dds_voice_osc #(
   parameter int unsigned OUT_W      = 12,
   parameter int unsigned SAMPLE_DIV = 2048,
   parameter int unsigned GLIDE_DIV  = 4096
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [31:0]      ADDER,
   input  logic             GATE,
   input  logic [1:0]       WAVE,
   input  logic [7:0]       PW,
   input  logic [3:0]       GLIDE,
   output logic [OUT_W-1:0] OUT,
   output logic             OUT_VALID,
   output logic             PHASE_WRAP
);

   localparam int unsigned SCW = $clog2(SAMPLE_DIV);
   localparam int unsigned GCW = (GLIDE_DIV > 1) ? $clog2(GLIDE_DIV) : 1;
   localparam logic [OUT_W-1:0] MID  = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic [OUT_W-1:0] FULL = {OUT_W{1'b1}};

   logic [31:0]        acc;
   logic [31:0]        inc;
   logic               gate_q;
   logic [SCW-1:0]     samp_cnt;
   logic [GCW-1:0]     glide_cnt;

   logic               rise;
   logic               samp_tc;
   logic               glide_tc;
   logic               carry;
   logic [31:0]        sum;
   logic signed [32:0] diff;
   logic signed [32:0] shifted;
   logic [31:0]        step;
   logic [31:0]        inc_next;
   logic [OUT_W-1:0]   tri_t;
   logic [OUT_W-1:0]   wave_val;

   // Event decode and accumulator add
   always_comb begin
      rise         = GATE & ~gate_q;
      samp_tc      = (samp_cnt == SCW'(SAMPLE_DIV - 1));
      glide_tc     = (glide_cnt == GCW'(GLIDE_DIV - 1));
      {carry, sum} = {1'b0, acc} + {1'b0, inc};
   end

   // Glide step: shifted difference, forced to +/-1 when it rounds to zero so INC lands exactly
   always_comb begin
      diff    = $signed({1'b0, ADDER}) - $signed({1'b0, inc});
      shifted = diff >>> GLIDE;
      if (shifted == '0 && diff != '0)
         step = diff[32] ? 32'hFFFF_FFFF : 32'd1;
      else
         step = shifted[31:0];
      if (GLIDE == 4'd0)
         inc_next = ADDER;
      else if (glide_tc)
         inc_next = inc + step;
      else
         inc_next = inc;
   end

   // Waveform shaping from the current accumulator
   always_comb begin
      tri_t = acc[30 -: OUT_W];
      case (WAVE)
         2'd0:    wave_val = acc[31 -: OUT_W];
         2'd1:    wave_val = (acc[31:24] < PW) ? FULL : '0;
         2'd2:    wave_val = acc[31] ? ~tri_t : tri_t;
         default: wave_val = MID;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         acc        <= '0;
         inc        <= '0;
         gate_q     <= 1'b0;
         samp_cnt   <= '0;
         glide_cnt  <= '0;
         OUT        <= MID;
         OUT_VALID  <= 1'b0;
         PHASE_WRAP <= 1'b0;
      end else begin
         gate_q    <= GATE;
         samp_cnt  <= samp_tc ? '0 : samp_cnt + SCW'(1);
         glide_cnt <= glide_tc ? '0 : glide_cnt + GCW'(1);
         inc       <= inc_next;
         if (rise) begin
            acc        <= '0;
            PHASE_WRAP <= 1'b0;
         end else begin
            acc        <= sum;
            PHASE_WRAP <= carry;
         end
         OUT_VALID <= samp_tc;
         if (samp_tc)
            OUT <= GATE ? wave_val : MID;
      end
   end

endmodule
